// File: rtl/reg_file_scoreboard.sv
// 16 x DATA_W register file with two one-hot-select read ports,
// write-to-read bypass and a per-register pending-write scoreboard.
module reg_file_scoreboard #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        SrcReg1,
  input  logic [3:0]        SrcReg2,
  output logic [DATA_W-1:0] SrcData1,
  output logic [DATA_W-1:0] SrcData2,
  output logic              Src1Ready,
  output logic              Src2Ready,
  input  logic              WriteReg,
  input  logic [3:0]        DstReg,
  input  logic [DATA_W-1:0] DstData,
  input  logic              IssueValid,
  input  logic [3:0]        IssueReg,
  input  logic              Flush,
  output logic [4:0]        BusyCount
);

  logic [DATA_W-1:0] regs_q [16];
  logic [15:0]       busy_q;
  logic [15:0]       busy_d;
  logic [15:0]       wl1;
  logic [15:0]       wl2;
  logic              wr_en;
  logic              byp1;
  logic              byp2;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;

  assign wr_en = WriteReg && (DstReg != 4'd0);
  assign wl1   = 16'd1 << SrcReg1;
  assign wl2   = 16'd1 << SrcReg2;
  assign byp1  = wr_en && (DstReg == SrcReg1);
  assign byp2  = wr_en && (DstReg == SrcReg2);

  // R0 is never written, so its storage slot stays zero
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    for (int i = 0; i < 16; i++) begin
      rd1 = rd1 | (regs_q[i] & {DATA_W{wl1[i]}});
      rd2 = rd2 | (regs_q[i] & {DATA_W{wl2[i]}});
    end
  end

  assign SrcData1 = byp1 ? DstData : rd1;
  assign SrcData2 = byp2 ? DstData : rd2;

  assign Src1Ready = ~busy_q[SrcReg1]
                   | (WriteReg && (DstReg == SrcReg1));
  assign Src2Ready = ~busy_q[SrcReg2]
                   | (WriteReg && (DstReg == SrcReg2));

  // Issue set outranks a same-cycle writeback clear
  always_comb begin
    busy_d = busy_q;
    for (int i = 1; i < 16; i++) begin
      if (Flush)
        busy_d[i] = 1'b0;
      else if (IssueValid && (IssueReg == 4'(i)))
        busy_d[i] = 1'b1;
      else if (WriteReg && (DstReg == 4'(i)))
        busy_d[i] = 1'b0;
    end
    busy_d[0] = 1'b0;
  end

  always_comb begin
    BusyCount = '0;
    for (int i = 0; i < 16; i++)
      BusyCount = BusyCount + 5'(busy_q[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      for (int i = 0; i < 16; i++)
        regs_q[i] <= '0;
    end else begin
      busy_q <= busy_d;
      if (wr_en)
        regs_q[DstReg] <= DstData;
    end
  end

endmodule
